// File: rtl/hmem_arbiter_if.sv
// hmem_arbiter_if: bus bundle between the two cache hmem ports, the arbiter
// and the next memory level.
//   i_req_*   : I-cache request side (read only)
//   d_req_*   : D-cache request side (load or writeback store)
//   mem_req_* : shared port toward the next memory level
//   grant     : one-hot {D,I} ownership of the shared port, 00 = idle
//   *_stall_cycles : saturating per-requester wait counters
// Modports: slave = arbiter view, master = environment (caches + memory) view.
interface hmem_arbiter_if #(
  parameter int XLEN            = 32,
  parameter int STALL_CNT_WIDTH = 32
);
  logic                       i_req_valid;
  logic [XLEN-1:0]            i_req_address;
  logic                       i_req_fulfilled;
  logic                       d_req_valid;
  logic                       d_req_operation;
  logic [XLEN-1:0]            d_req_address;
  logic [XLEN-1:0]            d_req_store_word;
  logic                       d_req_fulfilled;
  logic [XLEN-1:0]            req_loaded_word;
  logic                       mem_req_valid;
  logic                       mem_req_operation;
  logic [XLEN-1:0]            mem_req_address;
  logic [XLEN-1:0]            mem_req_store_word;
  logic [XLEN-1:0]            mem_req_loaded_word;
  logic                       mem_req_fulfilled;
  logic [1:0]                 grant;
  logic [STALL_CNT_WIDTH-1:0] i_stall_cycles;
  logic [STALL_CNT_WIDTH-1:0] d_stall_cycles;

  modport slave (
    input  i_req_valid, i_req_address,
    input  d_req_valid, d_req_operation, d_req_address, d_req_store_word,
    input  mem_req_loaded_word, mem_req_fulfilled,
    output i_req_fulfilled, d_req_fulfilled, req_loaded_word,
    output mem_req_valid, mem_req_operation, mem_req_address, mem_req_store_word,
    output grant, i_stall_cycles, d_stall_cycles
  );

  modport master (
    output i_req_valid, i_req_address,
    output d_req_valid, d_req_operation, d_req_address, d_req_store_word,
    output mem_req_loaded_word, mem_req_fulfilled,
    input  i_req_fulfilled, d_req_fulfilled, req_loaded_word,
    input  mem_req_valid, mem_req_operation, mem_req_address, mem_req_store_word,
    input  grant, i_stall_cycles, d_stall_cycles
  );
endinterface

// File: rtl/hmem_arbiter.sv
// hmem_arbiter: round-robin arbiter sharing one next-level memory port between
// a read-only I-cache and a read/write D-cache. Whole line bursts are granted
// atomically; ownership only changes by passing through IDLE.
// Ports:
//   clk     : clock, all state updates on posedge
//   reset_n : asynchronous active-low reset
//   bus     : hmem_arbiter_if.slave bundle (requests, memory port, grant,
//             stall counters)
module hmem_arbiter #(
  parameter int XLEN            = 32,
  parameter int LINE_SIZE       = 32,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  hmem_arbiter_if.slave  bus
);
  localparam int BURST_LEN = LINE_SIZE / 4;
  localparam int BEAT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  // State codes double as the one-hot {D,I} grant vector.
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  if (XLEN != 32) begin : g_bad_xlen
    $error("hmem_arbiter: only XLEN=32 is supported");
  end
  if ((LINE_SIZE % 4) != 0 || LINE_SIZE < 4) begin : g_bad_line
    $error("hmem_arbiter: LINE_SIZE must be a non-zero multiple of 4");
  end

  logic [1:0]                 state, state_next;
  logic [BEAT_W-1:0]          beat, beat_next;
  logic                       last_grant, last_grant_next;
  logic                       owner_valid;
  logic [STALL_CNT_WIDTH-1:0] i_stall, d_stall;

  assign owner_valid = (state == GRANT_D) ? bus.d_req_valid : bus.i_req_valid;

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next      = state;
    beat_next       = beat;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        // The requester that did not own the last burst wins a tie, so the
        // first tie after reset (last_grant = I) goes to D.
        if (bus.i_req_valid && bus.d_req_valid)
          state_next = (last_grant == LG_I) ? GRANT_D : GRANT_I;
        else if (bus.i_req_valid)
          state_next = GRANT_I;
        else if (bus.d_req_valid)
          state_next = GRANT_D;
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_req_fulfilled) begin
          if (beat == LAST_BEAT) begin
            state_next      = IDLE;
            beat_next       = '0;
            last_grant_next = (state == GRANT_D) ? LG_D : LG_I;
          end else begin
            beat_next = beat + BEAT_W'(1);
          end
        end else if (!owner_valid) begin
          // Owner dropped its request mid-burst: release the port early.
          state_next      = IDLE;
          beat_next       = '0;
          last_grant_next = (state == GRANT_D) ? LG_D : LG_I;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      beat       <= '0;
      last_grant <= LG_I;
    end else begin
      state      <= state_next;
      beat       <= beat_next;
      last_grant <= last_grant_next;
    end
  end

  // Saturating wait counters; they count every cycle a request is pending
  // and the port belongs to someone else or to nobody.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_stall <= '0;
      d_stall <= '0;
    end else begin
      if (bus.i_req_valid && (state != GRANT_I) && (i_stall != '1))
        i_stall <= i_stall + STALL_CNT_WIDTH'(1);
      if (bus.d_req_valid && (state != GRANT_D) && (d_stall != '1))
        d_stall <= d_stall + STALL_CNT_WIDTH'(1);
    end
  end

  // Request fields pass through unregistered; requesters hold them stable
  // until their beat is fulfilled.
  always_comb begin
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_operation  = 1'b0;
    bus.mem_req_address    = '0;
    bus.mem_req_store_word = '0;
    bus.i_req_fulfilled    = 1'b0;
    bus.d_req_fulfilled    = 1'b0;
    case (state)
      GRANT_I: begin
        bus.mem_req_valid   = bus.i_req_valid;
        bus.mem_req_address = bus.i_req_address;
        bus.i_req_fulfilled = bus.mem_req_fulfilled;
      end
      GRANT_D: begin
        bus.mem_req_valid      = bus.d_req_valid;
        bus.mem_req_operation  = bus.d_req_operation;
        bus.mem_req_address    = bus.d_req_address;
        bus.mem_req_store_word = bus.d_req_store_word;
        bus.d_req_fulfilled    = bus.mem_req_fulfilled;
      end
      default: ;
    endcase
  end

  assign bus.grant           = state;
  assign bus.req_loaded_word = bus.mem_req_loaded_word;
  assign bus.i_stall_cycles  = i_stall;
  assign bus.d_stall_cycles  = d_stall;

  // Simulation-time protocol checks.
  a_grant_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.grant));
  a_valid_granted : assert property (@(posedge clk) disable iff (!reset_n)
    bus.mem_req_valid |-> (bus.grant != 2'b00));
  a_i_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (bus.i_req_valid && !bus.i_req_fulfilled) |=>
      (!bus.i_req_valid || $stable(bus.i_req_address)));
  a_d_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (bus.d_req_valid && !bus.d_req_fulfilled) |=>
      (!bus.d_req_valid || $stable({bus.d_req_operation, bus.d_req_address,
                                    bus.d_req_store_word})));
endmodule

// File: tb/tb_hmem_arbiter.sv
// tb_hmem_arbiter: directed self-checking bench for hmem_arbiter. Inputs are
// driven and outputs sampled around the falling edge; the design updates on
// the rising edge. A second instance with 3-bit stall counters exercises
// counter saturation.
module tb_hmem_arbiter;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  hmem_arbiter_if #(.XLEN(32), .STALL_CNT_WIDTH(32)) bus ();
  hmem_arbiter_if #(.XLEN(32), .STALL_CNT_WIDTH(3))  sbus ();

  hmem_arbiter #(.XLEN(32), .LINE_SIZE(32), .STALL_CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  hmem_arbiter #(.XLEN(32), .LINE_SIZE(32), .STALL_CNT_WIDTH(3)) dut_small (
    .clk(clk), .reset_n(reset_n), .bus(sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.i_req_valid = 1'b0;          bus.i_req_address = '0;
    bus.d_req_valid = 1'b0;          bus.d_req_operation = 1'b0;
    bus.d_req_address = '0;          bus.d_req_store_word = '0;
    bus.mem_req_loaded_word = '0;    bus.mem_req_fulfilled = 1'b0;
    sbus.i_req_valid = 1'b0;         sbus.i_req_address = '0;
    sbus.d_req_valid = 1'b0;         sbus.d_req_operation = 1'b0;
    sbus.d_req_address = '0;         sbus.d_req_store_word = '0;
    sbus.mem_req_loaded_word = '0;   sbus.mem_req_fulfilled = 1'b0;
  endtask

  // Returns at a falling edge with reset released; the next rising edge is
  // the first active cycle.
  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    bus.mem_req_fulfilled = 1'b1;
    #1;
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL reset grant: got %b want 00", bus.grant); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL reset mem_req_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if ({bus.i_req_fulfilled, bus.d_req_fulfilled} !== 2'b00) $display("FAIL reset fulfilled: got %b want 00", {bus.i_req_fulfilled, bus.d_req_fulfilled}); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.i_stall_cycles !== 32'd0) $display("FAIL reset i_stall: got %0d want 0", bus.i_stall_cycles); else n_pass++;
    n_checks++; if (bus.d_stall_cycles !== 32'd0) $display("FAIL reset d_stall: got %0d want 0", bus.d_stall_cycles); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_i_only();
    int pulses;
    pulses = 0;
    reset_dut();
    bus.i_req_valid = 1'b1;
    bus.i_req_address = 32'h0000_1000;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b01) $display("FAIL i_only grant: got %b want 01", bus.grant); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL i_only mem_req_valid: got %b want 1", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.mem_req_operation !== 1'b0) $display("FAIL i_only op: got %b want 0", bus.mem_req_operation); else n_pass++;
    for (int b = 0; b < 8; b++) begin
      bus.mem_req_fulfilled = 1'b1;
      bus.mem_req_loaded_word = 32'hC0DE_0000 + 32'(b);
      #1;
      if (bus.i_req_fulfilled === 1'b1) pulses++;
      n_checks++; if (bus.grant !== 2'b01) $display("FAIL i_only beat%0d grant: got %b want 01", b, bus.grant); else n_pass++;
      n_checks++; if (bus.mem_req_address !== 32'h0000_1000 + 32'(4 * b)) $display("FAIL i_only beat%0d addr: got %h want %h", b, bus.mem_req_address, 32'h0000_1000 + 32'(4 * b)); else n_pass++;
      n_checks++; if (bus.req_loaded_word !== 32'hC0DE_0000 + 32'(b)) $display("FAIL i_only beat%0d loaded: got %h want %h", b, bus.req_loaded_word, 32'hC0DE_0000 + 32'(b)); else n_pass++;
      n_checks++; if (bus.d_req_fulfilled !== 1'b0) $display("FAIL i_only beat%0d d_fulfilled: got %b want 0", b, bus.d_req_fulfilled); else n_pass++;
      @(negedge clk);
      bus.i_req_address = bus.i_req_address + 32'd4;
    end
    bus.mem_req_fulfilled = 1'b0;
    bus.i_req_valid = 1'b0;
    #1;
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL i_only end grant: got %b want 00", bus.grant); else n_pass++;
    n_checks++; if (pulses !== 8) $display("FAIL i_only pulses: got %0d want 8", pulses); else n_pass++;
    n_checks++; if (bus.i_stall_cycles !== 32'd1) $display("FAIL i_only i_stall: got %0d want 1", bus.i_stall_cycles); else n_pass++;
    n_checks++; if (bus.d_stall_cycles !== 32'd0) $display("FAIL i_only d_stall: got %0d want 0", bus.d_stall_cycles); else n_pass++;
  endtask

  task automatic test_tie();
    reset_dut();
    bus.i_req_valid = 1'b1;  bus.i_req_address = 32'h0000_1100;
    bus.d_req_valid = 1'b1;  bus.d_req_operation = 1'b0;
    bus.d_req_address = 32'h0000_5000;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b10) $display("FAIL tie first grant: got %b want 10", bus.grant); else n_pass++;
    n_checks++; if (bus.mem_req_address !== 32'h0000_5000) $display("FAIL tie d addr: got %h want 00005000", bus.mem_req_address); else n_pass++;
    for (int b = 0; b < 8; b++) begin
      bus.mem_req_fulfilled = 1'b1;
      #1;
      n_checks++; if ({bus.d_req_fulfilled, bus.i_req_fulfilled} !== 2'b10) $display("FAIL tie beat%0d fulfilled{d,i}: got %b want 10", b, {bus.d_req_fulfilled, bus.i_req_fulfilled}); else n_pass++;
      @(negedge clk);
    end
    bus.mem_req_fulfilled = 1'b0;
    #1;
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL tie gap grant: got %b want 00", bus.grant); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b01) $display("FAIL tie second grant: got %b want 01", bus.grant); else n_pass++;
    n_checks++; if (bus.mem_req_address !== 32'h0000_1100) $display("FAIL tie i addr: got %h want 00001100", bus.mem_req_address); else n_pass++;
    n_checks++; if (bus.i_stall_cycles !== 32'd10) $display("FAIL tie i_stall: got %0d want 10", bus.i_stall_cycles); else n_pass++;
    n_checks++; if (bus.d_stall_cycles !== 32'd2) $display("FAIL tie d_stall: got %0d want 2", bus.d_stall_cycles); else n_pass++;
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL tie early release grant: got %b want 00", bus.grant); else n_pass++;
    n_checks++; if (bus.d_stall_cycles !== 32'd2) $display("FAIL tie d_stall hold: got %0d want 2", bus.d_stall_cycles); else n_pass++;
  endtask

  task automatic test_writeback();
    reset_dut();
    bus.i_req_valid = 1'b1;  bus.i_req_address = 32'h0000_1000;
    bus.d_req_valid = 1'b1;  bus.d_req_operation = 1'b1;
    bus.d_req_address = 32'h0000_2000;
    bus.d_req_store_word = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b10) $display("FAIL wb grant: got %b want 10", bus.grant); else n_pass++;
    for (int b = 0; b < 8; b++) begin
      bus.mem_req_fulfilled = 1'b1;
      #1;
      n_checks++; if (bus.mem_req_operation !== 1'b1) $display("FAIL wb beat%0d op: got %b want 1", b, bus.mem_req_operation); else n_pass++;
      n_checks++; if (bus.mem_req_store_word !== 32'hDEAD_BEEF) $display("FAIL wb beat%0d store: got %h want deadbeef", b, bus.mem_req_store_word); else n_pass++;
      n_checks++; if (bus.mem_req_address !== 32'h0000_2000 + 32'(4 * b)) $display("FAIL wb beat%0d addr: got %h want %h", b, bus.mem_req_address, 32'h0000_2000 + 32'(4 * b)); else n_pass++;
      n_checks++; if ({bus.d_req_fulfilled, bus.i_req_fulfilled} !== 2'b10) $display("FAIL wb beat%0d fulfilled{d,i}: got %b want 10", b, {bus.d_req_fulfilled, bus.i_req_fulfilled}); else n_pass++;
      @(negedge clk);
      bus.d_req_address = bus.d_req_address + 32'd4;
    end
    // D now wants its line fill; store data left on the bus on purpose.
    bus.mem_req_fulfilled = 1'b0;
    bus.d_req_operation = 1'b0;
    bus.d_req_address = 32'h0000_3000;
    #1;
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL wb gap grant: got %b want 00", bus.grant); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b01) $display("FAIL wb next grant: got %b want 01", bus.grant); else n_pass++;
    n_checks++; if (bus.mem_req_store_word !== 32'h0) $display("FAIL wb i store: got %h want 0", bus.mem_req_store_word); else n_pass++;
    n_checks++; if (bus.mem_req_address !== 32'h0000_1000) $display("FAIL wb i addr: got %h want 00001000", bus.mem_req_address); else n_pass++;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL wb i release grant: got %b want 00", bus.grant); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b10) $display("FAIL wb fill grant: got %b want 10", bus.grant); else n_pass++;
    n_checks++; if ({bus.mem_req_operation, bus.mem_req_address} !== {1'b0, 32'h0000_3000}) $display("FAIL wb fill op/addr: got %b/%h want 0/00003000", bus.mem_req_operation, bus.mem_req_address); else n_pass++;
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL wb fill release grant: got %b want 00", bus.grant); else n_pass++;
  endtask

  task automatic test_spurious();
    reset_dut();
    bus.mem_req_fulfilled = 1'b1;
    bus.mem_req_loaded_word = 32'h1234_5678;
    #1;
    n_checks++; if ({bus.i_req_fulfilled, bus.d_req_fulfilled} !== 2'b00) $display("FAIL spurious fulfilled: got %b want 00", {bus.i_req_fulfilled, bus.d_req_fulfilled}); else n_pass++;
    n_checks++; if (bus.req_loaded_word !== 32'h1234_5678) $display("FAIL spurious loaded: got %h want 12345678", bus.req_loaded_word); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL spurious grant: got %b want 00", bus.grant); else n_pass++;
    // A following burst must still need all 8 beats (beat counter untouched).
    bus.mem_req_fulfilled = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.i_req_address = 32'h0000_8000;
    @(negedge clk);
    for (int b = 0; b < 7; b++) begin
      bus.mem_req_fulfilled = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (bus.grant !== 2'b01) $display("FAIL spurious after 7 beats grant: got %b want 01", bus.grant); else n_pass++;
    @(negedge clk);
    bus.mem_req_fulfilled = 1'b0;
    bus.i_req_valid = 1'b0;
    #1;
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL spurious after 8 beats grant: got %b want 00", bus.grant); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    bus.i_req_valid = 1'b1;
    bus.i_req_address = 32'h0000_6000;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      bus.mem_req_fulfilled = 1'b1;
      @(negedge clk);
      bus.i_req_address = bus.i_req_address + 32'd4;
    end
    bus.mem_req_fulfilled = 1'b1;
    #1;
    n_checks++; if (bus.i_req_fulfilled !== 1'b1) $display("FAIL midrst beat3 fulfilled: got %b want 1", bus.i_req_fulfilled); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL midrst mem_req_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL midrst grant: got %b want 00", bus.grant); else n_pass++;
    n_checks++; if (bus.i_req_fulfilled !== 1'b0) $display("FAIL midrst i_fulfilled: got %b want 0", bus.i_req_fulfilled); else n_pass++;
    n_checks++; if (bus.i_stall_cycles !== 32'd0) $display("FAIL midrst i_stall: got %0d want 0", bus.i_stall_cycles); else n_pass++;
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    bus.d_req_valid = 1'b1;
    bus.d_req_address = 32'h0000_4000;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b10) $display("FAIL midrst d grant: got %b want 10", bus.grant); else n_pass++;
    n_checks++; if (bus.mem_req_address !== 32'h0000_4000) $display("FAIL midrst d addr: got %h want 00004000", bus.mem_req_address); else n_pass++;
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.grant !== 2'b00) $display("FAIL midrst d release grant: got %b want 00", bus.grant); else n_pass++;
  endtask

  task automatic test_saturation();
    int expected;
    reset_dut();
    sbus.d_req_valid = 1'b1;
    sbus.d_req_address = 32'h0000_7000;
    @(negedge clk);
    n_checks++; if (sbus.grant !== 2'b10) $display("FAIL sat d grant: got %b want 10", sbus.grant); else n_pass++;
    sbus.i_req_valid = 1'b1;
    sbus.i_req_address = 32'h0000_7100;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      expected = (k < 7) ? k : 7;
      n_checks++; if (sbus.i_stall_cycles !== 3'(expected)) $display("FAIL sat cycle%0d i_stall: got %0d want %0d", k, sbus.i_stall_cycles, expected); else n_pass++;
    end
    n_checks++; if (sbus.d_stall_cycles !== 3'd1) $display("FAIL sat d_stall: got %0d want 1", sbus.d_stall_cycles); else n_pass++;
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_i_only();
    test_tie();
    test_writeback();
    test_spurious();
    test_reset_mid_burst();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
